// File: rtl/exu_wbu.sv
// Writeback unit: merges ALU and LSU results onto the single regfile write port,
// buffering loads in a small squashable FIFO. Optional operand bypass: WBU_BYPASS_EN.
module exu_wbu #(
  parameter int XLEN  = 32,
  parameter int RFIDX = 5,
  parameter int DEPTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_alu_rdwen,
  input  logic [RFIDX-1:0]        i_alu_rdidx,
  input  logic [XLEN-1:0]         i_alu_rdwdata,
  input  logic                    i_lsu_valid,
  output logic                    o_lsu_ready,
  input  logic [RFIDX-1:0]        i_lsu_rdidx,
  input  logic [XLEN-1:0]         i_lsu_rdwdata,
  output logic                    o_rf_wen,
  output logic [RFIDX-1:0]        o_rf_widx,
  output logic [XLEN-1:0]         o_rf_wdata,
  output logic [$clog2(DEPTH):0]  o_pending
`ifdef WBU_BYPASS_EN
  ,
  input  logic [RFIDX-1:0]        i_rs1idx,
  input  logic [RFIDX-1:0]        i_rs2idx,
  output logic                    o_rs1_hit,
  output logic                    o_rs2_hit,
  output logic [XLEN-1:0]         o_rs1_data,
  output logic [XLEN-1:0]         o_rs2_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     rptr_q, wptr_q;
  logic              fvld_q [DEPTH];
  logic [RFIDX-1:0]  fidx_q [DEPTH];
  logic [XLEN-1:0]   fdat_q [DEPTH];

  logic              rf_wen_q;
  logic [RFIDX-1:0]  rf_widx_q;
  logic [XLEN-1:0]   rf_wdata_q;

  logic              alu_wr, lsu_acc, deq, direct, enq;
  logic              wr_en;
  logic [RFIDX-1:0]  wr_idx;
  logic [XLEN-1:0]   wr_data;

  assign o_lsu_ready = !i_rst && (count_q < (AW+1)'(DEPTH));
  assign o_pending   = count_q;
  assign o_rf_wen    = rf_wen_q;
  assign o_rf_widx   = rf_widx_q;
  assign o_rf_wdata  = rf_wdata_q;

  // An asserted ALU valid owns the port even for x0, so the FIFO only drains on ALU-idle cycles.
  always_comb begin
    alu_wr  = i_alu_rdwen && (i_alu_rdidx != '0);
    lsu_acc = i_lsu_valid && o_lsu_ready;
    deq     = 1'b0;
    direct  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = i_alu_rdidx;
    wr_data = i_alu_rdwdata;
    if (i_alu_rdwen) begin
      wr_en = alu_wr;
    end else if (count_q != '0) begin
      deq     = 1'b1;
      wr_en   = fvld_q[rptr_q];
      wr_idx  = fidx_q[rptr_q];
      wr_data = fdat_q[rptr_q];
    end else if (lsu_acc) begin
      direct  = 1'b1;
      wr_en   = (i_lsu_rdidx != '0);
      wr_idx  = i_lsu_rdidx;
      wr_data = i_lsu_rdwdata;
    end
    enq = lsu_acc && !direct && (i_lsu_rdidx != '0) &&
          !(alu_wr && (i_lsu_rdidx == i_alu_rdidx));
    count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_widx_q  <= '0;
      rf_wdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fvld_q[i] <= 1'b0;
    end else begin
      count_q <= count_d;
      if (deq) rptr_q <= rptr_q + AW'(1);
      if (enq) wptr_q <= wptr_q + AW'(1);
      // Older loads to the same rd lose to the ALU write; they still pop in order.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alu_wr && (fidx_q[i] == i_alu_rdidx)) fvld_q[i] <= 1'b0;
      end
      if (enq) begin
        fvld_q[wptr_q] <= 1'b1;
        fidx_q[wptr_q] <= i_lsu_rdidx;
        fdat_q[wptr_q] <= i_lsu_rdwdata;
      end
      rf_wen_q <= wr_en;
      if (wr_en) begin
        rf_widx_q  <= wr_idx;
        rf_wdata_q <= wr_data;
      end
    end
  end

`ifdef WBU_BYPASS_EN
  logic [RFIDX-1:0] rs_idx  [2];
  logic             rs_hit  [2];
  logic [XLEN-1:0]  rs_data [2];

  // Sources applied oldest to youngest so the last match wins.
  always_comb begin
    rs_idx[0] = i_rs1idx;
    rs_idx[1] = i_rs2idx;
    for (int unsigned p = 0; p < 2; p++) begin
      rs_hit[p]  = 1'b0;
      rs_data[p] = '0;
      if (lsu_acc && (i_lsu_rdidx == rs_idx[p])) begin
        rs_hit[p]  = 1'b1;
        rs_data[p] = i_lsu_rdwdata;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (((AW+1)'(k) < count_q) && fvld_q[AW'(rptr_q + AW'(k))] &&
            (fidx_q[AW'(rptr_q + AW'(k))] == rs_idx[p])) begin
          rs_hit[p]  = 1'b1;
          rs_data[p] = fdat_q[AW'(rptr_q + AW'(k))];
        end
      end
      if (rf_wen_q && (rf_widx_q == rs_idx[p])) begin
        rs_hit[p]  = 1'b1;
        rs_data[p] = rf_wdata_q;
      end
      if (i_alu_rdwen && (i_alu_rdidx == rs_idx[p])) begin
        rs_hit[p]  = 1'b1;
        rs_data[p] = i_alu_rdwdata;
      end
      if (rs_idx[p] == '0) begin
        rs_hit[p]  = 1'b0;
        rs_data[p] = '0;
      end
    end
  end

  assign o_rs1_hit  = rs_hit[0];
  assign o_rs2_hit  = rs_hit[1];
  assign o_rs1_data = rs_data[0];
  assign o_rs2_data = rs_data[1];
`endif

endmodule

// File: tb/tb_exu_wbu.sv
// Bench for exu_wbu: directed vector table, hand sequences and random traffic
// against a queue-based reference model. Bypass checks compile with WBU_BYPASS_EN.
module tb_exu_wbu;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, alu_en, lsu_v;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_d, lsu_d;
  logic        lsu_rdy, rf_wen;
  logic [4:0]  rf_widx;
  logic [31:0] rf_wdata;
  logic [1:0]  pending;
`ifdef WBU_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_data, rs2_data;
`endif

  always #5 clk = ~clk;

  exu_wbu #(.XLEN(32), .RFIDX(5), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_rdwen(alu_en), .i_alu_rdidx(alu_rd), .i_alu_rdwdata(alu_d),
    .i_lsu_valid(lsu_v), .o_lsu_ready(lsu_rdy),
    .i_lsu_rdidx(lsu_rd), .i_lsu_rdwdata(lsu_d),
    .o_rf_wen(rf_wen), .o_rf_widx(rf_widx), .o_rf_wdata(rf_wdata),
    .o_pending(pending)
`ifdef WBU_BYPASS_EN
    , .i_rs1idx(rs1), .i_rs2idx(rs2),
    .o_rs1_hit(rs1_hit), .o_rs2_hit(rs2_hit),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending loads kept as an ordered list; squash = mark dead.
  typedef struct { int unsigned rd; logic [31:0] d; bit live; } ent_t;
  ent_t        mq[$];
  bit          m_wen = 0;
  int unsigned m_idx = 0;
  logic [31:0] m_data = '0;
  bit          synced = 0;

  task automatic model_update();
    bit acc, took, w;
    int unsigned widx;
    logic [31:0] wd;
    if (rst) begin
      mq.delete();
      m_wen = 0; m_idx = 0; m_data = '0; synced = 1;
      return;
    end
    acc = lsu_v && (mq.size() < DEPTH);
    took = 0; w = 0; widx = 0; wd = '0;
    if (alu_en) begin
      if (alu_rd != 0) begin w = 1; widx = alu_rd; wd = alu_d; end
    end else if (mq.size() > 0) begin
      ent_t e = mq.pop_front();
      if (e.live) begin w = 1; widx = e.rd; wd = e.d; end
    end else if (acc) begin
      took = 1;
      if (lsu_rd != 0) begin w = 1; widx = lsu_rd; wd = lsu_d; end
    end
    if (alu_en && alu_rd != 0)
      foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 0;
    if (acc && !took && lsu_rd != 0 && !(alu_en && alu_rd != 0 && alu_rd == lsu_rd))
      mq.push_back('{rd: lsu_rd, d: lsu_d, live: 1'b1});
    m_wen = w;
    if (w) begin m_idx = widx; m_data = wd; end
  endtask

`ifdef WBU_BYPASS_EN
  task automatic bp_ref(input int unsigned idx, output bit hit, output logic [31:0] d);
    hit = 0; d = '0;
    if (idx == 0) return;
    if (alu_en && alu_rd == idx) begin hit = 1; d = alu_d; return; end
    if (m_wen && m_idx == idx) begin hit = 1; d = m_data; return; end
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].live && mq[i].rd == idx) begin hit = 1; d = mq[i].d; return; end
    if (!rst && lsu_v && mq.size() < DEPTH && lsu_rd == idx) begin hit = 1; d = lsu_d; end
  endtask
`endif

  task automatic step();
    #1;
`ifdef WBU_BYPASS_EN
    if (synced) begin
      bit h; logic [31:0] d;
      bp_ref(rs1, h, d);
      chk("m_rs1_hit", 32'(rs1_hit), 32'(h));
      if (h) chk("m_rs1_data", rs1_data, d);
      bp_ref(rs2, h, d);
      chk("m_rs2_hit", 32'(rs2_hit), 32'(h));
      if (h) chk("m_rs2_data", rs2_data, d);
    end
`endif
    @(posedge clk);
    model_update();
    #1;
    chk("m_wen", 32'(rf_wen), 32'(m_wen));
    chk("m_widx", 32'(rf_widx), m_idx);
    chk("m_wdata", rf_wdata, m_data);
    chk("m_pending", 32'(pending), 32'(mq.size()));
    chk("m_ready", 32'(lsu_rdy), 32'(!rst && mq.size() < DEPTH));
  endtask

  task automatic drive(input bit r, input bit ae, input int unsigned ard, input int unsigned ad,
                       input bit lv, input int unsigned lrd, input int unsigned ld);
    rst = r; alu_en = ae; alu_rd = 5'(ard); alu_d = ad;
    lsu_v = lv; lsu_rd = 5'(lrd); lsu_d = ld;
  endtask

  typedef struct {
    bit r, ae; int unsigned ard, ad;
    bit lv; int unsigned lrd, ld;
    bit ew; int unsigned ei, ed, ep; bit er;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit r, bit ae, int unsigned ard, int unsigned ad,
                             bit lv, int unsigned lrd, int unsigned ld,
                             bit ew, int unsigned ei, int unsigned ed, int unsigned ep, bit er);
    vec_t t;
    t.r = r; t.ae = ae; t.ard = ard; t.ad = ad; t.lv = lv; t.lrd = lrd; t.ld = ld;
    t.ew = ew; t.ei = ei; t.ed = ed; t.ep = ep; t.er = er;
    return t;
  endfunction

  initial begin
`ifdef WBU_BYPASS_EN
    rs1 = '0; rs2 = '0;
`endif
    drive(1, 0, 0, 0, 0, 0, 0);
    //              rst alu rd data       lsu rd data    | wen idx data     pend rdy
    tbl.push_back(v(1, 1, 3, 'h9,        0, 0, 0,         0, 0, 0,         0, 0));
    tbl.push_back(v(1, 1, 3, 'h9,        0, 0, 0,         0, 0, 0,         0, 0));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         0, 0, 0,         0, 1));
    tbl.push_back(v(0, 1, 5, 'h1234,     0, 0, 0,         1, 5, 'h1234,    0, 1));
    tbl.push_back(v(0, 1, 0, 'hDEAD,     0, 0, 0,         0, 5, 'h1234,    0, 1));
    tbl.push_back(v(0, 1, 1, 'h100,      1, 2, 'hAA,      1, 1, 'h100,     1, 1));
    tbl.push_back(v(0, 1, 1, 'h101,      1, 3, 'hBB,      1, 1, 'h101,     2, 0));
    tbl.push_back(v(0, 1, 1, 'h102,      1, 4, 'hCC,      1, 1, 'h102,     2, 0));
    tbl.push_back(v(0, 0, 0, 0,          1, 4, 'hCC,      1, 2, 'hAA,      1, 1));
    tbl.push_back(v(0, 0, 0, 0,          1, 4, 'hCC,      1, 3, 'hBB,      1, 1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         1, 4, 'hCC,      0, 1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         0, 4, 'hCC,      0, 1));
    tbl.push_back(v(0, 1, 1, 'h200,      1, 7, 'h11,      1, 1, 'h200,     1, 1));
    tbl.push_back(v(0, 1, 7, 'h22,       0, 0, 0,         1, 7, 'h22,      1, 1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         0, 7, 'h22,      0, 1));
    tbl.push_back(v(0, 0, 0, 0,          1, 9, 'h99,      1, 9, 'h99,      0, 1));
    tbl.push_back(v(0, 0, 0, 0,          1, 0, 'h77,      0, 9, 'h99,      0, 1));
    tbl.push_back(v(0, 1, 3, 'h300,      1, 3, 'h333,     1, 3, 'h300,     0, 1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         0, 3, 'h300,     0, 1));
    tbl.push_back(v(0, 1, 1, 'h400,      1, 5, 'h55,      1, 1, 'h400,     1, 1));
    tbl.push_back(v(0, 1, 1, 'h401,      1, 6, 'h66,      1, 1, 'h401,     2, 0));
    tbl.push_back(v(1, 1, 1, 'h402,      0, 0, 0,         0, 0, 0,         0, 0));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         0, 0, 0,         0, 1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0,         0, 0, 0,         0, 1));

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ae, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      step();
      chk($sformatf("vec%0d wen", i), 32'(rf_wen), 32'(tbl[i].ew));
      chk($sformatf("vec%0d widx", i), 32'(rf_widx), tbl[i].ei);
      chk($sformatf("vec%0d wdata", i), rf_wdata, tbl[i].ed);
      chk($sformatf("vec%0d pending", i), 32'(pending), tbl[i].ep);
      chk($sformatf("vec%0d ready", i), 32'(lsu_rdy), 32'(tbl[i].er));
    end

`ifdef WBU_BYPASS_EN
    drive(0, 1, 1, 'h1, 1, 4, 'h55);
    step();
    drive(0, 1, 1, 'h2, 0, 0, 0);
    rs1 = 5'd4; rs2 = 5'd0;
    #1;
    chk("bp fifo hit", 32'(rs1_hit), 32'd1);
    chk("bp fifo data", rs1_data, 32'h55);
    chk("bp x0 hit", 32'(rs2_hit), 32'd0);
    step();
    drive(0, 1, 4, 'h66, 0, 0, 0);
    #1;
    chk("bp alu hit", 32'(rs1_hit), 32'd1);
    chk("bp alu data", rs1_data, 32'h66);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("bp drain pending", 32'(pending), 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom);
`ifdef WBU_BYPASS_EN
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
`endif
      step();
    end

    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
